// File: rtl/datapath_sequencer_if.sv
// -----------------------------------------------------------------------------
// datapath_sequencer_if
//   Request/response channels between the instruction-issue logic and the
//   datapath sequencer.
//
//   Request  : in_valid / in_ready handshake carrying in_op, in_a, in_b.
//   Response : out_valid / out_ready handshake carrying out_result, out_flags.
//
//   modport master : the issuing side (drives requests, consumes responses).
//   modport slave  : the sequencer side.
// -----------------------------------------------------------------------------
interface datapath_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_op;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [DATA_W-1:0] out_flags;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/datapath_sequencer.sv
// -----------------------------------------------------------------------------
// datapath_sequencer
//   Control-side counterpart of the 8-bit datapath. Accepts one operation per
//   request handshake, strobes the datapath register loads (A, then B, then C
//   with the ALU selector applied), captures result and flags, and returns them
//   on the response channel. The opcode is passed through undecoded.
//
//   Ports
//     clock, reset           : clock and asynchronous active-high reset
//     bus (slave modport)    : request / response channels
//     operando1, operando2   : operands to the datapath (latched a / b)
//     alu_op                 : ALU selector, latched op during EXEC/CAPTURE
//     reg_load_a/b/c         : datapath register write enables
//     dp_result, dp_flags    : datapath register C and ALU flags
//     busy                   : high whenever an operation is in progress
//
//   Optional build macro DATAPATH_SEQ_PERF_EN adds:
//     op_count     [15:0]    : completed responses, wrapping
//     stall_cycles [15:0]    : response cycles stalled by out_ready, saturating
// -----------------------------------------------------------------------------
module datapath_sequencer #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 8
) (
    input  logic              clock,
    input  logic              reset,
    datapath_sequencer_if.slave bus,
    output logic [DATA_W-1:0] operando1,
    output logic [DATA_W-1:0] operando2,
    output logic [OP_W-1:0]   alu_op,
    output logic              reg_load_a,
    output logic              reg_load_b,
    output logic              reg_load_c,
    input  logic [DATA_W-1:0] dp_result,
    input  logic [DATA_W-1:0] dp_flags,
    output logic              busy
`ifdef DATAPATH_SEQ_PERF_EN
    ,
    output logic [15:0]       op_count,
    output logic [15:0]       stall_cycles
`endif
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_A  = 3'd1,
        LOAD_B  = 3'd2,
        EXEC    = 3'd3,
        CAPTURE = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t            state_reg;
    logic [OP_W-1:0]   op_reg;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic [DATA_W-1:0] result_reg;
    logic [DATA_W-1:0] flags_reg;
    logic [OP_W-1:0]   alu_op_reg;
    logic              load_a_reg;
    logic              load_b_reg;
    logic              load_c_reg;
    logic              in_ready_reg;
    logic              out_valid_reg;
    logic              busy_reg;

    // Every output is a register that is set together with the state it
    // belongs to, so the outputs always agree with state_reg and no input
    // reaches an output combinationally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            op_reg        <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            result_reg    <= '0;
            flags_reg     <= '0;
            alu_op_reg    <= '0;
            load_a_reg    <= 1'b0;
            load_b_reg    <= 1'b0;
            load_c_reg    <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            // Strobes are single-cycle pulses; only the transition into their
            // own state raises them.
            load_a_reg <= 1'b0;
            load_b_reg <= 1'b0;
            load_c_reg <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_reg       <= bus.in_op;
                        a_reg        <= bus.in_a;
                        b_reg        <= bus.in_b;
                        state_reg    <= LOAD_A;
                        load_a_reg   <= 1'b1;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                    end
                end
                LOAD_A: begin
                    state_reg  <= LOAD_B;
                    load_b_reg <= 1'b1;
                end
                LOAD_B: begin
                    state_reg  <= EXEC;
                    load_c_reg <= 1'b1;
                    alu_op_reg <= op_reg;
                end
                EXEC: begin
                    // alu_op stays applied through CAPTURE so the
                    // combinational flags are stable when sampled.
                    state_reg <= CAPTURE;
                end
                CAPTURE: begin
                    result_reg    <= dp_result;
                    flags_reg     <= dp_flags;
                    alu_op_reg    <= '0;
                    out_valid_reg <= 1'b1;
                    state_reg     <= RESP;
                end
                RESP: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    alu_op_reg    <= '0;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_reg;
    assign bus.out_valid  = out_valid_reg;
    assign bus.out_result = result_reg;
    assign bus.out_flags  = flags_reg;
    assign operando1      = a_reg;
    assign operando2      = b_reg;
    assign alu_op         = alu_op_reg;
    assign reg_load_a     = load_a_reg;
    assign reg_load_b     = load_b_reg;
    assign reg_load_c     = load_c_reg;
    assign busy           = busy_reg;

`ifdef DATAPATH_SEQ_PERF_EN
    logic [15:0] op_count_reg;
    logic [15:0] stall_cycles_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_count_reg     <= '0;
            stall_cycles_reg <= '0;
        end else if (state_reg == RESP) begin
            if (bus.out_ready) begin
                op_count_reg <= op_count_reg + 16'd1;
            end else if (stall_cycles_reg != 16'hFFFF) begin
                stall_cycles_reg <= stall_cycles_reg + 16'd1;
            end
        end
    end

    assign op_count     = op_count_reg;
    assign stall_cycles = stall_cycles_reg;
`endif

endmodule
